ipf_fault_sequencer: RTL

Protection sequencer for the CPLD gate-drive path. It consumes the debounced fault lines produced by the per-channel input glitch filters and gates the PWM enable. It latches and prioritises faults, runs a cool-down / auto-retry schedule, and enters lockout after repeated trips until the DSP clears it. It sits between the filtered fault inputs and the PWM output stage.

---
 rtl/ipf_fault_sequencer_if.sv | 33 +++
 rtl/ipf_fault_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/ipf_fault_sequencer_if.sv
// ============================================================================
// Module   : ipf_fault_sequencer_if
// Brief    : Fault-line, DSP request and status bundle for ipf_fault_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ipf_fault_sequencer_if #(
    parameter int N_CH = 4
) ();
    logic [N_CH-1:0] Flt_D;
    logic [N_CH-1:0] Mask;
    logic            Run_Req;
    logic            Clr_Req;
    logic            PWM_EN;
    logic [N_CH-1:0] Flt_Latch;
    logic [N_CH-1:0] First_Flt;
    logic [1:0]      Retry_Cnt;
    logic            Lockout;
    logic [2:0]      State;

    modport master (
        output Flt_D, Mask, Run_Req, Clr_Req,
        input  PWM_EN, Flt_Latch, First_Flt, Retry_Cnt, Lockout, State
    );

    modport slave (
        input  Flt_D, Mask, Run_Req, Clr_Req,
        output PWM_EN, Flt_Latch, First_Flt, Retry_Cnt, Lockout, State
    );
endinterface

`default_nettype wire

// File: rtl/ipf_fault_sequencer.sv
// ============================================================================
// Module   : ipf_fault_sequencer
// Brief    : Gate-drive protection sequencer; option macro FLT_SEQ_AUTORETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ipf_fault_sequencer #(
    parameter int N_CH      = 4,
    parameter int COOL_CYC  = 50000,
    parameter int CNT_W     = 16,
    parameter int MAX_RETRY = 3
) (
    input wire logic              CLK_50M,
    input wire logic              Rst_n,
    ipf_fault_sequencer_if.slave  seq_if
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_TRIP = 3'd2,
        ST_COOL = 3'd3,
        ST_LOCK = 3'd4
    } state_t;

    if (COOL_CYC < 1 || COOL_CYC > (2 ** CNT_W) - 1 || MAX_RETRY < 0 || MAX_RETRY > 3) begin : g_bad_cfg
        $error("ipf_fault_sequencer: COOL_CYC/CNT_W/MAX_RETRY out of range");
    end

    state_t          state_q;
    logic            pwm_q;
    logic            lock_q;
    logic [N_CH-1:0] latch_q;
    logic [N_CH-1:0] first_q;

    logic [N_CH-1:0] act;
    logic            fault;
    logic [N_CH-1:0] first_d;

    assign act     = seq_if.Flt_D & ~seq_if.Mask;
    assign fault   = |act;
    // Isolates the lowest set bit: the lowest-index channel wins a tie.
    assign first_d = act & (~act + N_CH'(1));

`ifdef FLT_SEQ_AUTORETRY_EN
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(COOL_CYC - 1);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       retry_q;
`endif

    always_ff @(posedge CLK_50M) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            pwm_q   <= 1'b0;
            lock_q  <= 1'b0;
            latch_q <= '0;
            first_q <= '0;
`ifdef FLT_SEQ_AUTORETRY_EN
            cnt_q   <= '0;
            retry_q <= 2'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    pwm_q <= 1'b0;
                    if (seq_if.Clr_Req) begin
                        latch_q <= '0;
                        first_q <= '0;
                    end
                    if (seq_if.Run_Req && !fault) begin
                        state_q <= ST_RUN;
                        pwm_q   <= 1'b1;
`ifdef FLT_SEQ_AUTORETRY_EN
                        cnt_q   <= '0;
`endif
                    end
                end

                ST_RUN: begin
                    if (fault) begin
                        state_q <= ST_TRIP;
                        pwm_q   <= 1'b0;
                        latch_q <= latch_q | act;
                        first_q <= first_d;
                    end else begin
`ifdef FLT_SEQ_AUTORETRY_EN
                        // A full cool-down length of clean running forgives earlier trips.
                        if (cnt_q == CNT_LAST) begin
                            retry_q <= 2'd0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
`endif
                        if (!seq_if.Run_Req) begin
                            state_q <= ST_IDLE;
                            pwm_q   <= 1'b0;
                        end
                    end
                end

                ST_TRIP: begin
                    latch_q <= latch_q | act;
`ifdef FLT_SEQ_AUTORETRY_EN
                    if (retry_q >= RETRY_MAX) begin
                        state_q <= ST_LOCK;
                        lock_q  <= 1'b1;
                    end else begin
                        retry_q <= retry_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_COOL;
                    end
`else
                    state_q <= ST_LOCK;
                    lock_q  <= 1'b1;
`endif
                end

`ifdef FLT_SEQ_AUTORETRY_EN
                ST_COOL: begin
                    latch_q <= latch_q | act;
                    if (fault) begin
                        cnt_q <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (seq_if.Run_Req) begin
                            state_q <= ST_RUN;
                            pwm_q   <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
`endif

                ST_LOCK: begin
                    if (seq_if.Clr_Req && !fault) begin
                        state_q <= ST_IDLE;
                        lock_q  <= 1'b0;
                        latch_q <= '0;
                        first_q <= '0;
`ifdef FLT_SEQ_AUTORETRY_EN
                        retry_q <= 2'd0;
`endif
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    pwm_q   <= 1'b0;
                    lock_q  <= 1'b0;
                end
            endcase
        end
    end

    assign seq_if.PWM_EN    = pwm_q;
    assign seq_if.Lockout   = lock_q;
    assign seq_if.Flt_Latch = latch_q;
    assign seq_if.First_Flt = first_q;
    assign seq_if.State     = state_q;
`ifdef FLT_SEQ_AUTORETRY_EN
    assign seq_if.Retry_Cnt = retry_q;
`else
    assign seq_if.Retry_Cnt = 2'd0;
`endif

endmodule

`default_nettype wire
